// File: rtl/maxpool_rx2.sv
// 2x2 stride-2 signed max pooling over a row-major conv stream, with a one-entry skid on the output.
// Optional macro POOL_RELU_EN clamps negative results to zero before the output path.
module maxpool_rx2 #(
  parameter int FMAP_W = 26,
  parameter int FMAP_H = 26
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic signed [15:0] conv_data,
  input  logic               conv_flag,
  output logic               ready_pool,
  input  logic               out_ready,
  output logic signed [15:0] pool_data,
  output logic               pool_valid,
  output logic               pool_last
);

  localparam int HALF_W = FMAP_W / 2;
  localparam int PW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int RW     = $clog2(FMAP_H);
  localparam logic [PW-1:0] PCOL_LAST = PW'(HALF_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(FMAP_H - 1);

  // Column is tracked as {pcol, col_odd} so pcol indexes the line buffer directly
  logic               col_odd;
  logic [PW-1:0]      pcol;
  logic [RW-1:0]      row;
  logic signed [15:0] pair;
  logic signed [15:0] line_buf [2**PW];
  logic signed [15:0] skid_data;
  logic               skid_valid;
  logic               skid_last;

  logic               accept;
  logic signed [15:0] hmax;
  logic signed [15:0] vmax;
  logic signed [15:0] res_data;
  logic               res_valid;
  logic               res_last;
  logic               out_free;

  // Datapath: horizontal and vertical signed max, result strobe
  always_comb begin
    accept    = start && conv_flag;
    hmax      = (conv_data > pair) ? conv_data : pair;
    vmax      = (hmax > line_buf[pcol]) ? hmax : line_buf[pcol];
    res_valid = accept && col_odd && row[0];
    res_last  = (row == ROW_LAST) && (pcol == PCOL_LAST);
`ifdef POOL_RELU_EN
    res_data  = vmax[15] ? 16'sd0 : vmax;
`else
    res_data  = vmax;
`endif
    out_free  = !pool_valid || out_ready;
  end

  assign ready_pool = !(skid_valid || (pool_valid && !out_ready));

  // Line buffer holds even-row horizontal maxima; contents survive start=0
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row[0]) begin
      line_buf[pcol] <= hmax;
    end
  end

  // Position counters and the even-column pair register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      col_odd <= 1'b0;
      pcol    <= '0;
      row     <= '0;
      pair    <= 16'sd0;
    end else if (!start) begin
      col_odd <= 1'b0;
      pcol    <= '0;
      row     <= '0;
      pair    <= 16'sd0;
    end else if (accept) begin
      if (!col_odd) begin
        pair    <= conv_data;
        col_odd <= 1'b1;
      end else begin
        col_odd <= 1'b0;
        if (pcol == PCOL_LAST) begin
          pcol <= '0;
          row  <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          pcol <= pcol + PW'(1);
        end
      end
    end
  end

  // Output register with skid; the skid entry always drains before a fresh result
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pool_data  <= 16'sd0;
      pool_valid <= 1'b0;
      pool_last  <= 1'b0;
      skid_data  <= 16'sd0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
    end else if (!start) begin
      pool_data  <= 16'sd0;
      pool_valid <= 1'b0;
      pool_last  <= 1'b0;
      skid_data  <= 16'sd0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        pool_data  <= skid_data;
        pool_valid <= 1'b1;
        pool_last  <= skid_last;
        if (res_valid) begin
          skid_data <= res_data;
          skid_last <= res_last;
        end else begin
          skid_valid <= 1'b0;
          skid_last  <= 1'b0;
        end
      end else if (res_valid) begin
        pool_data  <= res_data;
        pool_valid <= 1'b1;
        pool_last  <= res_last;
      end else begin
        pool_valid <= 1'b0;
        pool_last  <= 1'b0;
      end
    end else if (res_valid) begin
      skid_data  <= res_data;
      skid_valid <= 1'b1;
      skid_last  <= res_last;
    end else begin
      skid_valid <= skid_valid;
    end
  end

endmodule

// File: tb/tb_maxpool_rx2.sv
// Scoreboard bench for maxpool_rx2 on a 4x4 map: directed frames, skid hold, back-to-back and mid-frame abort.
module tb_maxpool_rx2;

  logic               clk;
  logic               n_reset;
  logic               start;
  logic signed [15:0] conv_data;
  logic               conv_flag;
  logic               ready_pool;
  logic               out_ready;
  logic signed [15:0] pool_data;
  logic               pool_valid;
  logic               pool_last;

  typedef struct {
    logic signed [15:0] d;
    logic               l;
    int                 c;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_cnt = 0;

  maxpool_rx2 #(.FMAP_W(4), .FMAP_H(4)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (start),
    .conv_data (conv_data),
    .conv_flag (conv_flag),
    .ready_pool(ready_pool),
    .out_ready (out_ready),
    .pool_data (pool_data),
    .pool_valid(pool_valid),
    .pool_last (pool_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every completed handshake is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (n_reset && pool_valid && out_ready) begin
      exp_t e;
      if (pool_last) last_cnt = last_cnt + 1;
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_result: got data %0d last %0b, scoreboard empty", pool_data, pool_last);
      end else begin
        e = sb.pop_front();
        if (pool_data !== e.d || pool_last !== e.l) begin
          errors = errors + 1;
          $display("FAIL result: got data %0d last %0b, want data %0d last %0b", pool_data, pool_last, e.d, e.l);
        end
        if (e.c >= 0) begin
          checks = checks + 1;
          if (cyc != e.c) begin
            errors = errors + 1;
            $display("FAIL latency: result %0d at cycle %0d, want cycle %0d", e.d, cyc, e.c);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] v, input bit has_res,
                      input logic signed [15:0] ed, input bit el, input bit lat);
    exp_t e;
    @(posedge clk); #1;
    conv_data = v;
    conv_flag = 1'b1;
    if (has_res) begin
      e.d = ed;
      e.l = el;
      e.c = lat ? cyc + 1 : -1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      conv_flag = 1'b0;
    end
  endtask

  // Sends base+from .. base+to; results arrive after indices 5, 7, 13, 15
  task automatic frame(input int base, input int from, input int to,
                       input logic signed [15:0] e0, input logic signed [15:0] e1,
                       input logic signed [15:0] e2, input logic signed [15:0] e3,
                       input bit lat);
    for (int i = from; i <= to; i++) begin
      if (i == 5)       send(16'(base + i), 1'b1, e0, 1'b0, lat);
      else if (i == 7)  send(16'(base + i), 1'b1, e1, 1'b0, lat);
      else if (i == 13) send(16'(base + i), 1'b1, e2, 1'b0, lat);
      else if (i == 15) send(16'(base + i), 1'b1, e3, 1'b1, lat);
      else              send(16'(base + i), 1'b0, 16'sd0, 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int lc;
    n_reset   = 1'b0;
    start     = 1'b0;
    conv_data = 16'sd0;
    conv_flag = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", int'(pool_valid), 0);
    chk("reset_last", int'(pool_last), 0);
    chk("reset_data", int'(pool_data), 0);
    chk("reset_ready", int'(ready_pool), 1);
    #1;
    n_reset = 1'b1;
    start   = 1'b1;

    // Ramp 0..15
    frame(0, 0, 15, 16'sd5, 16'sd7, 16'sd13, 16'sd15, 1'b1);
    idle(1);
    drain();

    // Negative ramp -16..-1
`ifdef POOL_RELU_EN
    frame(-16, 0, 15, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b1);
`else
    frame(-16, 0, 15, -16'sd11, -16'sd9, -16'sd3, -16'sd1, 1'b1);
`endif
    idle(1);
    drain();

    // Hold downstream across two results: first in output, second in skid
    out_ready = 1'b0;
    frame(0, 0, 7, 16'sd5, 16'sd7, 16'sd0, 16'sd0, 1'b0);
    idle(3);
    @(negedge clk);
    chk("hold_ready_pool", int'(ready_pool), 0);
    chk("hold_valid", int'(pool_valid), 1);
    chk("hold_data", int'(pool_data), 5);
    @(negedge clk);
    chk("hold_data_stable", int'(pool_data), 5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("release_ready_pool", int'(ready_pool), 1);
    chk("release_valid", int'(pool_valid), 0);
    frame(0, 8, 15, 16'sd0, 16'sd0, 16'sd13, 16'sd15, 1'b1);
    idle(1);
    drain();

    // Two back-to-back frames
    lc = last_cnt;
    frame(0, 0, 15, 16'sd5, 16'sd7, 16'sd13, 16'sd15, 1'b1);
    frame(0, 0, 15, 16'sd5, 16'sd7, 16'sd13, 16'sd15, 1'b1);
    idle(1);
    drain();
    chk("b2b_last_count", last_cnt - lc, 2);

    // Abort by n_reset after 6 samples with result 5 parked in the output register
    out_ready = 1'b0;
    frame(0, 0, 5, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    idle(2);
    sb.delete();
    @(negedge clk);
    chk("partial_held", int'(pool_valid), 1);
    #1;
    n_reset = 1'b0;
    #2;
    chk("nreset_valid", int'(pool_valid), 0);
    chk("nreset_ready", int'(ready_pool), 1);
    @(posedge clk); #1;
    n_reset   = 1'b1;
    out_ready = 1'b1;
    frame(100, 0, 15, 16'sd105, 16'sd107, 16'sd113, 16'sd115, 1'b1);
    idle(1);
    drain();

    // Abort by dropping start after 6 samples
    out_ready = 1'b0;
    frame(0, 0, 5, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    idle(2);
    sb.delete();
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("start_clear_valid", int'(pool_valid), 0);
    chk("start_clear_data", int'(pool_data), 0);
    frame(100, 0, 15, 16'sd105, 16'sd107, 16'sd113, 16'sd115, 1'b1);
    idle(3);
    drain();

    chk("total_last_count", last_cnt, 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
